led_mode_ctrl: RTL and testbench
================================

Name: led_mode_ctrl

Overview:
- Generates the 3-bit LED mode code consumed by the LED driver stage: 0 = off, 1 = steady on, 2 = 0.1 s toggle blink, 3 = breathing PWM.
- A user push-button cycles the modes. An obstacle alarm input forces blink mode, then holds it for a fixed time after the obstacle clears.
- Sits between the board key/sensor pins and the LED driver, in the 24 MHz system clock domain.

Parameters:
- DEBOUNCE_CYC, 480_000, consecutive stable cycles needed to accept a key level change (20 ms at 24 MHz). Must be >= 2.
- ALARM_HOLD_CYC, 24_000_000, cycles blink is held after the obstacle input deasserts (1 s). Must be >= 1.

Ports:
- clk  in  1  system clock, 24 MHz
- rst  in  1  reset, asynchronous, active-low
- key_n  in  1  raw push-button, active-low, asynchronous to clk
- obstacle  in  1  obstacle detect level, active-high, asynchronous to clk
- led_mode  out  3  mode code to the LED driver; only values 0..3 are ever driven
- mode_chg  out  1  one-cycle pulse whenever led_mode changes value

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-low.
  - Reset state: led_mode = 0, mode_chg = 0, user mode = OFF, alarm inactive, all counters 0.
  - Synchronizers reset key side to 1 and obstacle side to 0.
  - Reset mid-operation aborts any debounce or alarm hold immediately.
- Input sync: key_n and obstacle each pass through a 2-FF synchronizer, giving key_s and obs_s.
- Debounce:
  - Debounced level key_db resets to 1.
  - Counter cnt clears whenever key_s == key_db.
  - While they differ, cnt increments each cycle. When it reaches DEBOUNCE_CYC-1 with key_s still differing, key_db <= key_s and cnt <= 0.
  - key_pulse = one cycle, on the cycle after key_db falls 1->0. Release generates no pulse.
  - Any key_s bounce shorter than DEBOUNCE_CYC cycles is ignored.
- User mode FSM, states OFF(0), ON(1), BLINK(2), BREATH(3):
  - On key_pulse: OFF->ON->BLINK->BREATH->OFF (wrap-around).
  - No other transitions.
- Alarm:
  - obs_s = 1: hold counter loaded with ALARM_HOLD_CYC and alarm_active = 1.
  - obs_s = 0 and counter > 0: counter decrements.
  - alarm_active clears on the cycle the counter reaches 0 with obs_s = 0.
  - Obstacle re-asserting during the hold reloads the counter.
- Output: led_mode is registered, next value = alarm_active ? 2 : user_mode.
  - mode_chg registered, = 1 for exactly one cycle when the registered led_mode differs from its previous value.
- Latency:
  - key_n falling (clean) to led_mode update: DEBOUNCE_CYC+4 cycles (2 sync + DEBOUNCE_CYC + pulse + output).
  - obstacle rising to led_mode = 2: 4 cycles.
- Simultaneous events:
  - key_pulse while alarm_active: user mode still advances. The change is invisible until the alarm ends, then led_mode jumps to the new user mode.
  - key_pulse on the same cycle the alarm starts: both take effect, output shows 2.
  - user mode already BLINK when the alarm starts or ends: led_mode stays 2 and mode_chg does not pulse.
- Counter widths: $clog2(param+1). No overflow possible; counters saturate by construction.

Decomposition:
- Shared package led_pkg:
  - LED_OFF = 3'd0, LED_ON = 3'd1, LED_BLINK = 3'd2, LED_BREATH = 3'd3.
  - SYS_CLK_HZ = 24_000_000.
  - Used by both this block and the LED driver.
- Sub-module key_debounce: synchronizer + debounce counter + falling-edge pulse.
  - Parameter DEBOUNCE_CYC; ports clk, rst, key_n, key_pulse.
  - Reusable for the car's other buttons.
- Alarm hold and mode FSM stay in led_mode_ctrl.

Test Plan (bench uses DEBOUNCE_CYC = 8, ALARM_HOLD_CYC = 20):
- Reset: assert rst low mid-run with led_mode = 3 -> led_mode = 0 and mode_chg = 0 immediately (async). Release; hold key_n = 1, obstacle = 0 -> led_mode stays 0.
- Clean presses:
  - Key low 20 cycles, then high -> led_mode 0->1 exactly 12 cycles after the first sampling edge, with a single mode_chg pulse.
  - Four such presses -> sequence 1,2,3,0.
- Bounce: key low 5 cycles, high 3, low 5, high -> no change. Then low 8+ cycles -> exactly one advance.
- Alarm:
  - Mode 1, obstacle high 10 cycles then low -> led_mode = 2 four cycles after rise.
  - Returns to 1 exactly ALARM_HOLD_CYC+1 cycles after obs_s falls.
  - mode_chg pulses on entry and exit.
- Alarm reload and key during alarm:
  - During hold, re-pulse obstacle -> hold restarts.
  - Press key twice during alarm (mode 1) -> led_mode stays 2, then exits directly to 3.
- Blink overlap: user mode 2, obstacle pulse -> led_mode constant 2 and mode_chg never asserts.

Source files
------------

// File: rtl/led_pkg.sv
// Shared LED definitions: mode codes seen by the LED driver, the user mode
// state type, and helpers to step and encode the user mode.
package led_pkg;

    localparam logic [2:0] LED_OFF    = 3'd0;
    localparam logic [2:0] LED_ON     = 3'd1;
    localparam logic [2:0] LED_BLINK  = 3'd2;
    localparam logic [2:0] LED_BREATH = 3'd3;

    localparam int SYS_CLK_HZ = 24_000_000;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ON     = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BREATH = 2'd3
    } user_mode_e;

    // Button cycle order, wrapping from BREATH back to OFF.
    function automatic user_mode_e next_mode(input user_mode_e m);
        user_mode_e r;
        case (m)
            MODE_OFF:    r = MODE_ON;
            MODE_ON:     r = MODE_BLINK;
            MODE_BLINK:  r = MODE_BREATH;
            default:     r = MODE_OFF;
        endcase
        return r;
    endfunction

    // User states are numbered to match the driver codes one-for-one.
    function automatic logic [2:0] mode_to_led(input user_mode_e m);
        return {1'b0, m};
    endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// Board-side signals of the LED mode controller: key/sensor pins in,
// mode code and change strobe out to the LED driver.
interface led_mode_ctrl_if;

    logic       key_n;
    logic       obstacle;
    logic [2:0] led_mode;
    logic       mode_chg;

    // Pin/driver side: drives the raw inputs, observes the mode outputs.
    modport master (
        output key_n,
        output obstacle,
        input  led_mode,
        input  mode_chg
    );

    // Controller side.
    modport slave (
        input  key_n,
        input  obstacle,
        output led_mode,
        output mode_chg
    );

endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a
// one-cycle pulse on the cycle after the debounced level falls (press only).
module key_debounce #(
    parameter int DEBOUNCE_CYC = 480_000
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic key_n,
    output logic key_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync_q;
    logic          key_s;
    logic          key_db_q, key_db_d;
    logic          key_db_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    assign key_s = sync_q[1];

    // Two-stage synchronizer; idles high like the released button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], key_n};
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYC samples.
    always_comb begin
        cnt_d    = '0;
        key_db_d = key_db_q;
        if (key_s != key_db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                key_db_d = key_s;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d = key_db_prev_q & ~key_db_q;
    end

    // Debounce state, previous level for edge detect, and the press pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            key_db_q      <= 1'b1;
            key_db_prev_q <= 1'b1;
            pulse_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_q;
            pulse_q       <= pulse_d;
        end
    end

    assign key_pulse = pulse_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: button-driven user mode cycling, with an obstacle
// alarm that forces blink and holds it for a fixed time after clearing.
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 480_000,
    parameter int ALARM_HOLD_CYC = 24_000_000
) (
    input  logic                  clk,
    input  logic                  rst,   // asynchronous, active-low
    led_mode_ctrl_if.slave        bus
);

    localparam int HW = $clog2(ALARM_HOLD_CYC + 1);

    logic          key_pulse;
    logic [1:0]    obs_sync_q;
    logic          obs_s;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          alarm_q, alarm_d;
    user_mode_e    user_mode_q, user_mode_d;
    logic [2:0]    led_mode_q, led_mode_d;
    logic          mode_chg_q, mode_chg_d;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_n     (bus.key_n),
        .key_pulse (key_pulse)
    );

    assign obs_s = obs_sync_q[1];

    // Obstacle synchronizer; idles low (no obstacle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) obs_sync_q <= 2'b00;
        else      obs_sync_q <= {obs_sync_q[0], bus.obstacle};
    end

    // Alarm hold: reload while the obstacle is seen, count down once it clears,
    // and drop the alarm on the same cycle the count reaches zero.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        alarm_d    = alarm_q;
        if (obs_s) begin
            hold_cnt_d = HW'(ALARM_HOLD_CYC);
            alarm_d    = 1'b1;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
            alarm_d    = (hold_cnt_d != '0);
        end else begin
            alarm_d    = 1'b0;
        end
    end

    // User mode next state: advances on every press, alarm or not.
    always_comb begin
        user_mode_d = user_mode_q;
        if (key_pulse) user_mode_d = next_mode(user_mode_q);
    end

    // Output selection; the strobe fires on the same edge the code changes.
    always_comb begin
        led_mode_d = alarm_q ? LED_BLINK : mode_to_led(user_mode_q);
        mode_chg_d = (led_mode_d != led_mode_q);
    end

    // State registers for alarm, user mode and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_q  <= '0;
            alarm_q     <= 1'b0;
            user_mode_q <= MODE_OFF;
            led_mode_q  <= LED_OFF;
            mode_chg_q  <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            alarm_q     <= alarm_d;
            user_mode_q <= user_mode_d;
            led_mode_q  <= led_mode_d;
            mode_chg_q  <= mode_chg_d;
        end
    end

    assign bus.led_mode = led_mode_q;
    assign bus.mode_chg = mode_chg_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl (DEBOUNCE_CYC = 8, ALARM_HOLD_CYC = 20).
// Stimulus pushes {expected mode, expected cycle} for every visible change;
// a monitor pops an entry on each mode_chg pulse.
module tb_led_mode_ctrl;
    import led_pkg::*;

    localparam int DEB      = 8;
    localparam int HOLD     = 20;
    // Latencies counted in rising edges after an input driven at a falling edge.
    localparam int KEY_LAT  = DEB + 5;   // 12 edges after the first sampling edge
    localparam int OBS_LAT  = 4;
    localparam int EXIT_LAT = HOLD + 3;  // 2 sync edges, then HOLD+1 after obs_s falls

    typedef struct {
        logic [2:0] mode;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    logic [2:0] prev_mode = 3'd0;

    led_mode_ctrl_if bus ();

    led_mode_ctrl #(
        .DEBOUNCE_CYC   (DEB),
        .ALARM_HOLD_CYC (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_out(input logic [2:0] m, input int at);
        exp_t e;
        e.mode = m;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // One clean press: low 20 cycles, high 20 cycles.
    task automatic press(input bit visible, input logic [2:0] m);
        @(negedge clk);
        bus.key_n = 1'b0;
        if (visible) expect_out(m, cyc + KEY_LAT);
        repeat (20) @(negedge clk);
        bus.key_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Monitor: every change must carry a strobe, and every strobe must match
    // the next scoreboard entry in value and cycle.
    always @(negedge clk) begin
        if (!rst) begin
            prev_mode = 3'd0;
        end else begin
            if ((bus.led_mode != prev_mode) || bus.mode_chg) begin
                tests++;
                if (!((bus.led_mode != prev_mode) && bus.mode_chg)) begin
                    fails++;
                    $display("FAIL chg_consistency: led_mode %0d->%0d mode_chg %0d at cycle %0d",
                             prev_mode, bus.led_mode, bus.mode_chg, cyc);
                end
            end
            if (bus.mode_chg) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_chg: got mode %0d at cycle %0d, want no change",
                             bus.led_mode, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.led_mode != e.mode || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL sb_out: got mode %0d at cycle %0d, want mode %0d at cycle %0d",
                                 bus.led_mode, cyc, e.mode, e.cyc);
                    end
                end
            end
            prev_mode = bus.led_mode;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_n    = 1'b1;
        bus.obstacle = 1'b0;
        rst          = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_led", int'(bus.led_mode), int'(LED_OFF));
        check("reset_chg", int'(bus.mode_chg), 0);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("idle_led", int'(bus.led_mode), int'(LED_OFF));

        // Clean presses walk the full cycle.
        press(1'b1, LED_ON);
        press(1'b1, LED_BLINK);
        press(1'b1, LED_BREATH);
        press(1'b1, LED_OFF);

        // Bounces shorter than the debounce window are ignored.
        @(negedge clk);
        bus.key_n = 1'b0;
        repeat (5) @(negedge clk);
        bus.key_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.key_n = 1'b0;
        repeat (5) @(negedge clk);
        bus.key_n = 1'b1;
        repeat (20) @(negedge clk);
        check("bounce_ignored", int'(bus.led_mode), int'(LED_OFF));
        press(1'b1, LED_ON);

        // Basic alarm: enter after 4 edges, exit HOLD+1 after obs_s falls.
        @(negedge clk);
        bus.obstacle = 1'b1;
        expect_out(LED_BLINK, cyc + OBS_LAT);
        repeat (10) @(negedge clk);
        bus.obstacle = 1'b0;
        expect_out(LED_ON, cyc + EXIT_LAT);
        repeat (HOLD + 10) @(negedge clk);
        check("alarm_exit", int'(bus.led_mode), int'(LED_ON));

        // Re-pulse during hold restarts the hold from the second fall.
        @(negedge clk);
        bus.obstacle = 1'b1;
        expect_out(LED_BLINK, cyc + OBS_LAT);
        repeat (3) @(negedge clk);
        bus.obstacle = 1'b0;
        repeat (10) @(negedge clk);
        bus.obstacle = 1'b1;
        repeat (2) @(negedge clk);
        bus.obstacle = 1'b0;
        expect_out(LED_ON, cyc + EXIT_LAT);
        repeat (HOLD + 10) @(negedge clk);
        check("reload_exit", int'(bus.led_mode), int'(LED_ON));

        // Two presses under alarm stay hidden, then exit straight to BREATH.
        @(negedge clk);
        bus.obstacle = 1'b1;
        expect_out(LED_BLINK, cyc + OBS_LAT);
        repeat (5) @(negedge clk);
        press(1'b0, LED_OFF);
        press(1'b0, LED_OFF);
        check("alarm_masks_key", int'(bus.led_mode), int'(LED_BLINK));
        bus.obstacle = 1'b0;
        expect_out(LED_BREATH, cyc + EXIT_LAT);
        repeat (HOLD + 10) @(negedge clk);
        check("alarm_key_exit", int'(bus.led_mode), int'(LED_BREATH));

        // Alarm while the user already chose blink: no visible change.
        press(1'b1, LED_OFF);
        press(1'b1, LED_ON);
        press(1'b1, LED_BLINK);
        @(negedge clk);
        bus.obstacle = 1'b1;
        repeat (5) @(negedge clk);
        bus.obstacle = 1'b0;
        repeat (HOLD + 10) @(negedge clk);
        check("blink_overlap", int'(bus.led_mode), int'(LED_BLINK));

        // Asynchronous reset from BREATH, asserted between clock edges.
        press(1'b1, LED_BREATH);
        check("pre_rst_led", int'(bus.led_mode), int'(LED_BREATH));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_led", int'(bus.led_mode), int'(LED_OFF));
        check("async_rst_chg", int'(bus.mode_chg), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", int'(bus.led_mode), int'(LED_OFF));

        check("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
